// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input controller: control encoding,
// joystick word bit positions and the PS/2 set-2 keyboard map for players 1/2.
package arcade_input_pkg;

  // Control index; values equal the joystick word bit of the same control.
  typedef enum logic [3:0] {
    CTL_RIGHT   = 4'd0,
    CTL_LEFT    = 4'd1,
    CTL_DOWN    = 4'd2,
    CTL_UP      = 4'd3,
    CTL_BTN1    = 4'd4,
    CTL_BTN2    = 4'd5,
    CTL_BTN3    = 4'd6,
    CTL_BTN4    = 4'd7,
    CTL_START   = 4'd8,
    CTL_COIN    = 4'd9,
    CTL_PAUSE   = 4'd10,
    CTL_SERVICE = 4'd11
  } ctl_e;

  localparam int NUM_CTL = 12;

  // Joystick word layout
  localparam int JOY_RIGHT       = 0;
  localparam int JOY_LEFT        = 1;
  localparam int JOY_DOWN        = 2;
  localparam int JOY_UP          = 3;
  localparam int JOY_BTN_BASE    = 4;   // buttons 1..4
  localparam int JOY_BTN_HI_BASE = 8;   // buttons 5..8 land on bits 12..15
  localparam int JOY_START       = 8;
  localparam int JOY_COIN        = 9;
  localparam int JOY_PAUSE       = 10;
  localparam int JOY_SERVICE     = 11;

  // Key map entry: code[8] is the E0 prefix bit; ext_req makes it significant.
  typedef struct packed {
    logic [8:0] code;
    logic       ext_req;
    ctl_e       ctl;
    logic [1:0] player;
  } key_ent_t;

  localparam int KEY_TABLE_LEN = 23;

  localparam key_ent_t KEY_TABLE [KEY_TABLE_LEN] = '{
    // Player 1: arrows, Ctrl, Alt, Space, Shift, 1, 5, P, 9
    '{9'h175, 1'b1, CTL_UP,      2'd0},
    '{9'h172, 1'b1, CTL_DOWN,    2'd0},
    '{9'h16B, 1'b1, CTL_LEFT,    2'd0},
    '{9'h174, 1'b1, CTL_RIGHT,   2'd0},
    '{9'h014, 1'b0, CTL_BTN1,    2'd0},
    '{9'h011, 1'b0, CTL_BTN2,    2'd0},
    '{9'h029, 1'b0, CTL_BTN3,    2'd0},
    '{9'h012, 1'b0, CTL_BTN4,    2'd0},
    '{9'h016, 1'b0, CTL_START,   2'd0},
    '{9'h02E, 1'b0, CTL_COIN,    2'd0},
    '{9'h04D, 1'b0, CTL_PAUSE,   2'd0},
    '{9'h046, 1'b0, CTL_SERVICE, 2'd0},
    // Player 2: R F D G, A, S, Q, W, 2, 6, 0 (no pause key)
    '{9'h02D, 1'b0, CTL_UP,      2'd1},
    '{9'h02B, 1'b0, CTL_DOWN,    2'd1},
    '{9'h023, 1'b0, CTL_LEFT,    2'd1},
    '{9'h034, 1'b0, CTL_RIGHT,   2'd1},
    '{9'h01C, 1'b0, CTL_BTN1,    2'd1},
    '{9'h01B, 1'b0, CTL_BTN2,    2'd1},
    '{9'h015, 1'b0, CTL_BTN3,    2'd1},
    '{9'h01D, 1'b0, CTL_BTN4,    2'd1},
    '{9'h01E, 1'b0, CTL_START,   2'd1},
    '{9'h036, 1'b0, CTL_COIN,    2'd1},
    '{9'h045, 1'b0, CTL_SERVICE, 2'd1}
  };

  // Arrow keys need the E0 prefix; all other keys ignore it.
  function automatic logic key_match(input key_ent_t ent, input logic [8:0] key);
    return ent.ext_req ? (ent.code == key) : (ent.code[7:0] == key[7:0]);
  endfunction

  // Joystick bit carrying fire button b (0-based).
  function automatic int joy_btn_bit(input int b);
    return (b < 4) ? (JOY_BTN_BASE + b) : (JOY_BTN_HI_BASE + b);
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulse.sv
// Coin pulse stretcher: a qualified rising edge of the raw coin level starts
// a fixed-length output pulse; edges during a pulse are ignored, and after
// reset the raw level must be seen low before any edge counts.
module coin_pulse
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_CYCLES = 16'd4800
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic raw,
  output logic pulse
);

  logic        raw_p0;
  logic        seen_low_p0;
  logic [15:0] cnt_p0;
  logic [15:0] cnt_nxt;

  // Next pulse count: run down an active pulse, else start on a qualified edge
  always_comb begin
    cnt_nxt = cnt_p0;
    if (cnt_p0 != 16'd0)
      cnt_nxt = cnt_p0 - 16'd1;
    else if (raw && !raw_p0 && seen_low_p0)
      cnt_nxt = COIN_CYCLES;
  end

  // Edge history, arming flag, counter and registered pulse output
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      raw_p0      <= 1'b0;
      seen_low_p0 <= 1'b0;
      cnt_p0      <= 16'd0;
      pulse       <= 1'b0;
    end else begin
      raw_p0 <= raw;
      if (!raw)
        seen_low_p0 <= 1'b1;
      cnt_p0 <= cnt_nxt;
      pulse  <= (cnt_nxt != 16'd0);
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input controller: merges PS/2 keyboard state with per-player
// joystick words, applies autofire to fire buttons and stretches coin edges.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS     = 2,
  parameter int          NUM_BUTTONS     = 4,
  parameter logic [15:0] COIN_CYCLES     = 16'd4800,
  parameter logic [23:0] AUTOFIRE_PERIOD = 24'd1600000
) (
  input  logic                             clk_sys,
  input  logic                             RESET,
  input  logic [10:0]                      ps2_key,
  input  logic [32*NUM_PLAYERS-1:0]        joystick,
  input  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] autofire_en,
  output logic [4*NUM_PLAYERS-1:0]         dir,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] buttons,
  output logic [NUM_PLAYERS-1:0]           start,
  output logic [NUM_PLAYERS-1:0]           coin,
  output logic [NUM_PLAYERS-1:0]           pause,
  output logic [NUM_PLAYERS-1:0]           service
);

  // Only players 1 and 2 have keyboard keys.
  localparam int KP = (NUM_PLAYERS < 2) ? NUM_PLAYERS : 2;
  localparam logic [23:0] AF_HALF = AUTOFIRE_PERIOD >> 1;
  localparam logic [23:0] AF_LAST = AUTOFIRE_PERIOD - 24'd1;

  logic                    tog_p0;
  logic                    prime_p0;
  logic [NUM_CTL-1:0]      key_p0 [KP];
  logic                    key_evt;
  logic [23:0]             af_cnt_p0;
  logic                    af_phase;
  logic [NUM_CTL-1:0]      raw_ctl [NUM_PLAYERS];
  logic [NUM_BUTTONS-1:0]  raw_btn [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  raw_coin;
  logic                    unused_bits;

  // The first edge after reset only primes the toggle copy.
  assign key_evt  = prime_p0 && (ps2_key[10] != tog_p0);
  assign af_phase = (af_cnt_p0 < AF_HALF);

  // Keyboard state: toggle tracking and per-key press/release registers
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      tog_p0   <= 1'b0;
      prime_p0 <= 1'b0;
      for (int p = 0; p < KP; p++)
        key_p0[p] <= '0;
    end else begin
      tog_p0   <= ps2_key[10];
      prime_p0 <= 1'b1;
      for (int p = 0; p < KP; p++)
        for (int i = 0; i < KEY_TABLE_LEN; i++)
          if (key_evt && KEY_TABLE[i].player == 2'(p) && key_match(KEY_TABLE[i], ps2_key[8:0]))
            key_p0[p][KEY_TABLE[i].ctl] <= ps2_key[9];
    end
  end

  // Free-running autofire phase counter
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET)
      af_cnt_p0 <= 24'd0;
    else if (af_cnt_p0 >= AF_LAST)
      af_cnt_p0 <= 24'd0;
    else
      af_cnt_p0 <= af_cnt_p0 + 24'd1;
  end

  // Raw control levels: keyboard OR joystick, plus upper-bank buttons from joystick
  always_comb begin
    unused_bits = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      raw_ctl[p] = joystick[32*p +: NUM_CTL];
    for (int p = 0; p < KP; p++)
      raw_ctl[p] = raw_ctl[p] | key_p0[p];
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 0; b < NUM_BUTTONS; b++)
        raw_btn[p][b] = (b < 4) ? raw_ctl[p][joy_btn_bit(b)] : joystick[32*p + joy_btn_bit(b)];
      raw_coin[p] = raw_ctl[p][JOY_COIN];
      unused_bits = unused_bits ^ (^raw_ctl[p]);
    end
    unused_bits = unused_bits ^ (^joystick);
  end

  // Registered direction, button and misc outputs
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      dir     <= '0;
      buttons <= '0;
      start   <= '0;
      pause   <= '0;
      service <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        dir[4*p +: 4] <= {raw_ctl[p][JOY_UP], raw_ctl[p][JOY_DOWN],
                          raw_ctl[p][JOY_LEFT], raw_ctl[p][JOY_RIGHT]};
        for (int b = 0; b < NUM_BUTTONS; b++)
          buttons[NUM_BUTTONS*p + b] <= autofire_en[NUM_BUTTONS*p + b]
                                        ? (raw_btn[p][b] & af_phase) : raw_btn[p][b];
        start[p]   <= raw_ctl[p][JOY_START];
        pause[p]   <= raw_ctl[p][JOY_PAUSE];
        service[p] <= raw_ctl[p][JOY_SERVICE];
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_coin
    coin_pulse #(
      .COIN_CYCLES(COIN_CYCLES)
    ) u_coin (
      .clk_sys(clk_sys),
      .RESET  (RESET),
      .raw    (raw_coin[gp]),
      .pulse  (coin[gp])
    );
  end

endmodule
